// File: rtl/vram_write_sched_m_pkg.sv
// vram_write_sched_m_pkg
//   Shared definitions for the VRAM write scheduler: default widths and
//   depth, the scheduler state encoding, and the width of one queued
//   CPU write (address concatenated above data).
package vram_write_sched_m_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;
    localparam int VRAM_DATA_WIDTH = 8;
    localparam int VRAM_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_DRAIN = 2'd1,
        SCHED_FILL  = 2'd2
    } sched_state_t;

    // A queue entry is {addr, data}.
    function automatic int entry_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/vram_write_sched_m_fifo.sv
// sync_fifo_m
//   Single-clock FIFO with a combinational head read.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (empties queue)
//     push/push_data  write an entry; ignored while full
//     pop             remove the head entry; ignored while empty
//     head_data       current head entry (valid while !empty)
//     full, empty     status flags
//     level           entry count 0..DEPTH, one bit wider than the pointers
module sync_fifo_m #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LVL_FULL);
    assign empty     = (level == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; the level
    // counter carries the extra bit that tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vram_write_sched_m.sv
// vram_write_sched_m
//   Sole owner of the gpu_m VRAM write port. CPU writes are queued and
//   drained only during vblank; a fill/DMA engine can take the bus
//   exclusively, during which gpu_hold freezes scan-out.
//   Ports:
//     clk_12_5875, rst                 pixel clock, sync active-high reset
//     in_vblank                        VRAM may be written
//     cpu_wr_valid/ready/addr/data     CPU write handshake into the queue
//     fill_req/grant/we/addr/data      fill engine request and write port
//     vram_we/addr/data                registered write port to gpu_m
//     gpu_hold                         registered, high while filling
//     fifo_level                       queued entries 0..FIFO_DEPTH
//   Optional build macro VRAM_WRITE_SCHED_STATS_EN adds:
//     stat_stall   saturating count of stalled CPU write cycles
//     stat_writes  wrapping count of vram_we cycles
module vram_write_sched_m
    import vram_write_sched_m_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_WIDTH,
    parameter int DATA_W     = VRAM_DATA_WIDTH,
    parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
) (
    input  logic                          clk_12_5875,
    input  logic                          rst,
    input  logic                          in_vblank,
    input  logic                          cpu_wr_valid,
    output logic                          cpu_wr_ready,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    input  logic                          fill_req,
    output logic                          fill_grant,
    input  logic                          fill_we,
    input  logic [ADDR_W-1:0]             fill_addr,
    input  logic [DATA_W-1:0]             fill_data,
    output logic                          vram_we,
    output logic [ADDR_W-1:0]             vram_addr,
    output logic [DATA_W-1:0]             vram_data,
    output logic                          gpu_hold,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef VRAM_WRITE_SCHED_STATS_EN
    ,
    output logic [15:0]                   stat_stall,
    output logic [15:0]                   stat_writes
`endif
);

    localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

    sched_state_t     state;
    logic [ENTRY_W-1:0] head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Ready is forced low while reset is asserted so nothing is taken
    // into a queue that is being discarded.
    assign cpu_wr_ready = ~rst & ~fifo_full;
    assign push         = cpu_wr_valid & cpu_wr_ready;

    // A pending fill request blocks popping immediately so the write
    // already in flight is the last one before the bus is handed over.
    assign pop = (state != SCHED_FILL) & in_vblank & ~fifo_empty & ~fill_req;

    sync_fifo_m #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_12_5875),
        .rst       (rst),
        .push      (push),
        .push_data ({cpu_wr_addr, cpu_wr_data}),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Scheduler state and every bus-facing output are registered together.
    // While in FILL the fill engine's port is forwarded one cycle late; a
    // pop forwards the queue head; otherwise the strobe drops and the
    // address/data lines keep their last value.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state      <= SCHED_IDLE;
            fill_grant <= 1'b0;
            gpu_hold   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_data  <= '0;
        end else begin
            if (fill_req) begin
                state      <= SCHED_FILL;
                fill_grant <= 1'b1;
                gpu_hold   <= 1'b1;
            end else if (pop) begin
                state      <= SCHED_DRAIN;
                fill_grant <= 1'b0;
                gpu_hold   <= 1'b0;
            end else begin
                state      <= SCHED_IDLE;
                fill_grant <= 1'b0;
                gpu_hold   <= 1'b0;
            end

            if (state == SCHED_FILL) begin
                vram_we   <= fill_we;
                vram_addr <= fill_addr;
                vram_data <= fill_data;
            end else if (pop) begin
                vram_we   <= 1'b1;
                vram_addr <= head_entry[ENTRY_W-1:DATA_W];
                vram_data <= head_entry[DATA_W-1:0];
            end else begin
                vram_we   <= 1'b0;
            end
        end
    end

`ifdef VRAM_WRITE_SCHED_STATS_EN
    // Stall counter saturates so a long stall never wraps to look healthy;
    // the write counter simply wraps.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            stat_stall  <= '0;
            stat_writes <= '0;
        end else begin
            if (cpu_wr_valid && !cpu_wr_ready && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
            if (vram_we)
                stat_writes <= stat_writes + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_write_sched_m.sv
// tb_vram_write_sched_m
//   Self-checking bench for vram_write_sched_m. A queue-based reference
//   model predicts every output each cycle; directed scenarios pin the
//   model with literal expectations, then a randomized phase runs.
//   Define VRAM_WRITE_SCHED_STATS_EN to also check the statistics ports.
module tb_vram_write_sched_m;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vblank;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        fill_req;
    logic        fill_grant;
    logic        fill_we;
    logic [11:0] fill_addr;
    logic [7:0]  fill_data;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic        gpu_hold;
    logic [3:0]  fifo_level;
`ifdef VRAM_WRITE_SCHED_STATS_EN
    logic [15:0] stat_stall;
    logic [15:0] stat_writes;
`endif

    always #5 clk = ~clk;

    vram_write_sched_m dut (
        .clk_12_5875  (clk),
        .rst          (rst),
        .in_vblank    (in_vblank),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .fill_req     (fill_req),
        .fill_grant   (fill_grant),
        .fill_we      (fill_we),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .gpu_hold     (gpu_hold),
        .fifo_level   (fifo_level)
`ifdef VRAM_WRITE_SCHED_STATS_EN
        ,
        .stat_stall   (stat_stall),
        .stat_writes  (stat_writes)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: the queue of accepted writes, whether the
    // fill engine owns the bus, and the expected registered write port.
    logic [19:0] m_q[$];
    bit          m_filling = 1'b0;
    bit          m_we = 1'b0;
    logic [11:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic [15:0] m_stall = '0;
    logic [15:0] m_writes = '0;
    bit          armed = 1'b0;

    // Log of every write the DUT issued, for order checks.
    logic [19:0] seen[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge using the inputs held over the cycle.
    always @(posedge clk) begin : model_p
        bit          ready_now;
        bit          can_pop;
        bit          take;
        logic [19:0] head;
        ready_now = !rst && (m_q.size() < DEPTH);
        if (rst) begin
            m_q.delete();
            m_filling = 1'b0;
            m_we      = 1'b0;
            m_addr    = '0;
            m_data    = '0;
            m_stall   = '0;
            m_writes  = '0;
            armed     = 1'b1;
        end else if (armed) begin
            if (cpu_wr_valid && !ready_now && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (m_we) m_writes = m_writes + 16'd1;
            can_pop = !m_filling && in_vblank && (m_q.size() > 0) && !fill_req;
            take    = cpu_wr_valid && ready_now;
            if (m_filling) begin
                m_we   = fill_we;
                m_addr = fill_addr;
                m_data = fill_data;
            end else if (can_pop) begin
                head = m_q.pop_front();
                m_we = 1'b1;
                {m_addr, m_data} = head;
            end else begin
                m_we = 1'b0;
            end
            if (take) m_q.push_back({cpu_wr_addr, cpu_wr_data});
            m_filling = fill_req;
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("cpu_wr_ready", cpu_wr_ready, (!rst && m_q.size() < DEPTH));
            checkOutput("fifo_level", fifo_level, m_q.size());
            checkOutput("vram_we", vram_we, m_we);
            checkOutput("vram_addr", vram_addr, m_addr);
            checkOutput("vram_data", vram_data, m_data);
            checkOutput("fill_grant", fill_grant, m_filling);
            checkOutput("gpu_hold", gpu_hold, m_filling);
`ifdef VRAM_WRITE_SCHED_STATS_EN
            checkOutput("stat_stall", stat_stall, m_stall);
            checkOutput("stat_writes", stat_writes, m_writes);
`endif
            if (vram_we) seen.push_back({vram_addr, vram_data});
        end
    end

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic applyStimulus(input bit valid, input logic [11:0] a, input logic [7:0] d,
                                 input bit vb, input bit freq, input bit fwe,
                                 input logic [11:0] fa, input logic [7:0] fd);
        cpu_wr_valid = valid;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        in_vblank    = vb;
        fill_req     = freq;
        fill_we      = fwe;
        fill_addr    = fa;
        fill_data    = fd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit vb, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, vb, 1'b0, 1'b0, '0, '0);
    endtask

    // Present one CPU write until it is accepted, bounded.
    task automatic pushOne(input logic [11:0] a, input logic [7:0] d, input bit vb);
        bit accepted;
        int guard;
        accepted = 1'b0;
        guard    = 0;
        while (!accepted && guard < 64) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = a;
            cpu_wr_data  = d;
            in_vblank    = vb;
            fill_req     = 1'b0;
            fill_we      = 1'b0;
            #1;
            accepted = cpu_wr_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        cpu_wr_valid = 1'b0;
        checkOutput("push_handshake", accepted, 1);
    endtask

    task automatic checkSeen(input string name, input logic [19:0] exp[$]);
        checkOutput({name, "_count"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            checkOutput(name, (i < seen.size()) ? seen[i] : 20'hFFFFF, exp[i]);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        logic [19:0] exp[$];
        bit vb;
        bit fr;

        rst = 1'b1;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        in_vblank = 1'b0; fill_req = 1'b0; fill_we = 1'b0;
        fill_addr = '0; fill_data = '0;

        // Reset values
        idle(1'b0, 2);
        checkOutput("reset_ready_low", cpu_wr_ready, 0);
        checkOutput("reset_level", fifo_level, 0);
        checkOutput("reset_vram_we", vram_we, 0);
        checkOutput("reset_grant", fill_grant, 0);
        rst = 1'b0;
        idle(1'b0, 1);
        checkOutput("ready_after_reset", cpu_wr_ready, 1);

        // Queue four writes outside vblank, then drain them
        pushOne(12'h800, 8'h0F, 1'b0);
        pushOne(12'h801, 8'h0F, 1'b0);
        pushOne(12'h802, 8'h00, 1'b0);
        pushOne(12'h803, 8'h07, 1'b0);
        seen.delete();
        idle(1'b0, 2);
        checkOutput("s1_level_queued", fifo_level, 4);
        checkOutput("s1_no_write", seen.size(), 0);
        idle(1'b1, 6);
        exp = '{20'h8000F, 20'h8010F, 20'h80200, 20'h80307};
        checkSeen("s1_order", exp);
        checkOutput("s1_level_drained", fifo_level, 0);

        // Overfill: ninth write is held until vblank frees a slot
        for (int i = 0; i < 8; i++) pushOne(12'h100 + 12'(i), 8'(i * 3 + 1), 1'b0);
        seen.delete();
        applyStimulus(1'b1, 12'h108, 8'h19, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 12'h108, 8'h19, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("s2_ready_full", cpu_wr_ready, 0);
        checkOutput("s2_level_full", fifo_level, 8);
        pushOne(12'h108, 8'h19, 1'b1);
        idle(1'b1, 12);
        exp.delete();
        for (int i = 0; i < 9; i++) exp.push_back({12'h100 + 12'(i), 8'(i * 3 + 1)});
        checkSeen("s2_order", exp);
`ifdef VRAM_WRITE_SCHED_STATS_EN
        checkOutput("s2_stall_nonzero", (stat_stall != 0), 1);
`endif

        // Fill takes the bus while three writes wait
        for (int i = 0; i < 3; i++) pushOne(12'h200 + 12'(i), 8'hA0 + 8'(i), 1'b0);
        seen.delete();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        checkOutput("s3_grant", fill_grant, 1);
        checkOutput("s3_hold", gpu_hold, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 12'(i), 8'h0F);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("s3_grant_released", fill_grant, 0);
        checkOutput("s3_hold_released", gpu_hold, 0);
        checkOutput("s3_level_kept", fifo_level, 3);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back({12'(i), 8'h0F});
        checkSeen("s3_fill", exp);
        seen.delete();
        idle(1'b1, 6);
        exp.delete();
        for (int i = 0; i < 3; i++) exp.push_back({12'h200 + 12'(i), 8'hA0 + 8'(i)});
        checkSeen("s3_drain", exp);

        // vblank ends after two pops
        for (int i = 0; i < 6; i++) pushOne(12'h300 + 12'(i), 8'h50 + 8'(i), 1'b0);
        seen.delete();
        idle(1'b1, 2);
        idle(1'b0, 3);
        checkOutput("s4_two_writes", seen.size(), 2);
        checkOutput("s4_level", fifo_level, 4);
        idle(1'b1, 8);
        exp.delete();
        for (int i = 0; i < 6; i++) exp.push_back({12'h300 + 12'(i), 8'h50 + 8'(i)});
        checkSeen("s4_order", exp);

        // Reset in the middle of a drain
        for (int i = 0; i < 6; i++) pushOne(12'h3A0 + 12'(i), 8'(i), 1'b0);
        idle(1'b1, 1);
        checkOutput("s5_level_before", fifo_level, 5);
        rst = 1'b1;
        idle(1'b1, 1);
        checkOutput("s5_ready_in_reset", cpu_wr_ready, 0);
        rst = 1'b0;
        in_vblank = 1'b0;
        #1;
        checkOutput("s5_level_cleared", fifo_level, 0);
        checkOutput("s5_we_cleared", vram_we, 0);
        checkOutput("s5_ready_after", cpu_wr_ready, 1);

        // Simultaneous push and pop
        idle(1'b0, 1);
        for (int i = 0; i < 3; i++) pushOne(12'h400 + 12'(i), 8'hC0 + 8'(i), 1'b0);
        seen.delete();
        pushOne(12'h403, 8'hC3, 1'b1);
        checkOutput("s6_level_same", fifo_level, 3);
        idle(1'b1, 8);
        exp.delete();
        for (int i = 0; i < 4; i++) exp.push_back({12'h400 + 12'(i), 8'hC0 + 8'(i)});
        checkSeen("s6_order", exp);

        // Randomized traffic against the model
        vb = 1'b0;
        fr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) vb = ~vb;
            if (!fr && $urandom_range(63) == 0) fr = 1'b1;
            else if (fr && $urandom_range(15) == 0) fr = 1'b0;
            rst = ($urandom_range(499) == 0);
            applyStimulus($urandom_range(1) == 1, 12'($urandom), 8'($urandom), vb, fr,
                          fr && ($urandom_range(1) == 1), 12'($urandom), 8'($urandom));
        end
        rst = 1'b0;
        idle(1'b1, 12);
        checkOutput("final_level_empty", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
